// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - shared types and constants for the alu4 write-back stage
package alu4_pkg;

    // ALU operation code encoding, carried through write-back as a tag
    localparam logic [1:0] CTL_0 = 2'd0;
    localparam logic [1:0] CTL_1 = 2'd1;
    localparam logic [1:0] CTL_2 = 2'd2;
    localparam logic [1:0] CTL_3 = 2'd3;

    // Architectural flag vector width: {zf, cf, sf}
    localparam int FLAG_W = 3;

    // One pending write-back: result, flags, op tag and destination index
    typedef struct packed {
        logic [3:0] res;
        logic       zf;
        logic       cf;
        logic       sf;
        logic [1:0] ctl;
        logic [1:0] rd;
    } alu4_wb_entry_t;

    // FIFO occupancy states
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    // Flag vector of an entry in architectural order
    function automatic logic [FLAG_W-1:0] entry_flags(input alu4_wb_entry_t e);
        return {e.zf, e.cf, e.sf};
    endfunction

endpackage

// File: rtl/alu4_wb_fifo.sv
// rtl/alu4_wb_fifo.sv - in-order circular buffer of pending write-back entries
module alu4_wb_fifo
    import alu4_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  alu4_wb_entry_t wdata,
    input  logic           pop,
    output logic [CW-1:0]  count,
    output logic           full,
    output logic           empty,
    output alu4_wb_entry_t head
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    alu4_wb_entry_t mem [DEPTH];
    logic [PW-1:0]  hd_ptr;
    logic [PW-1:0]  tl_ptr;
    occ_state_t     state;
    occ_state_t     state_nxt;
    logic [CW-1:0]  count_nxt;
    logic           do_push;
    logic           do_pop;

    // A push into a full buffer or a pop from an empty one is dropped here
    assign do_push = push && (state != OCC_FULL);
    assign do_pop  = pop && (state != OCC_EMPTY);

    assign full  = (state == OCC_FULL);
    assign empty = (state == OCC_EMPTY);
    assign head  = mem[hd_ptr];

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    // Next occupancy count and state; simultaneous push and pop keeps the count
    always_comb begin
        count_nxt = count;
        state_nxt = state;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        case (state)
            OCC_EMPTY: begin
                if (do_push) begin
                    state_nxt = (count_nxt == DEPTH_C) ? OCC_FULL : OCC_PARTIAL;
                end
            end
            OCC_PARTIAL: begin
                if (count_nxt == '0) begin
                    state_nxt = OCC_EMPTY;
                end else if (count_nxt == DEPTH_C) begin
                    state_nxt = OCC_FULL;
                end
            end
            OCC_FULL: begin
                if (do_pop) begin
                    state_nxt = OCC_PARTIAL;
                end
            end
            default: state_nxt = OCC_EMPTY;
        endcase
    end

    // Occupancy state, count and pointers; reset discards every pending entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= OCC_EMPTY;
            count  <= '0;
            hd_ptr <= '0;
            tl_ptr <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (do_push) begin
                tl_ptr <= ptr_inc(tl_ptr);
            end
            if (do_pop) begin
                hd_ptr <= ptr_inc(hd_ptr);
            end
        end
    end

    // Entry storage; slots are only read once written, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tl_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/alu4_wb.sv
// rtl/alu4_wb.sv - alu4 write-back stage: FIFO, register file, flags; optional ALU4_WB_BYPASS_EN read bypass
module alu4_wb
    import alu4_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_res,
    input  logic       in_zf,
    input  logic       in_cf,
    input  logic       in_sf,
    input  logic [1:0] in_ctl,
    input  logic [1:0] in_rd,
    input  logic       wb_stall,
    input  logic [1:0] ra_addr,
    input  logic [1:0] rb_addr,
    output logic [3:0] ra_data,
    output logic [3:0] rb_data,
    output logic       flag_zf,
    output logic       flag_cf,
    output logic       flag_sf,
    output logic [1:0] last_ctl,
    output logic [7:0] commit_cnt
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    alu4_wb_entry_t in_entry;
    alu4_wb_entry_t head;
    logic [CW-1:0]  occ;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           commit;
    logic           unused_full;
    logic [3:0]     rf [NREGS];

    assign in_entry = '{res: in_res, zf: in_zf, cf: in_cf, sf: in_sf,
                        ctl: in_ctl, rd: in_rd};

    // No pass-through when full: a pop this cycle does not free a slot until the edge
    assign in_ready = rst_n && (occ != DEPTH_C);
    assign push     = in_valid && in_ready;
    assign commit   = !fifo_empty && !wb_stall;

    // full is implied by the occupancy count compare above
    assign unused_full = fifo_full;

    alu4_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_entry),
        .pop   (commit),
        .count (occ),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Commit the head entry into architectural state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
            {flag_zf, flag_cf, flag_sf} <= '0;
            last_ctl   <= CTL_0;
            commit_cnt <= '0;
        end else if (commit) begin
            rf[head.rd]                 <= head.res;
            {flag_zf, flag_cf, flag_sf} <= entry_flags(head);
            last_ctl                    <= head.ctl;
            commit_cnt                  <= commit_cnt + 8'd1;
        end
    end

    // Operand read ports back to issue logic
    always_comb begin
`ifdef ALU4_WB_BYPASS_EN
        // Forward the result that commits on the coming edge
        ra_data = (commit && (head.rd == ra_addr)) ? head.res : rf[ra_addr];
        rb_data = (commit && (head.rd == rb_addr)) ? head.res : rf[rb_addr];
`else
        ra_data = rf[ra_addr];
        rb_data = rf[rb_addr];
`endif
    end

endmodule

// File: tb/tb_alu4_wb.sv
// tb/tb_alu4_wb.sv - randomized self-checking bench for alu4_wb against a queue model
module tb_alu4_wb;
    import alu4_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_res;
    logic       in_zf, in_cf, in_sf;
    logic [1:0] in_ctl;
    logic [1:0] in_rd;
    logic       wb_stall;
    logic [1:0] ra_addr, rb_addr;
    logic [3:0] ra_data, rb_data;
    logic       flag_zf, flag_cf, flag_sf;
    logic [1:0] last_ctl;
    logic [7:0] commit_cnt;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    // Reference model: pending entries in a queue, architectural state as plain arrays
    alu4_wb_entry_t q[$];
    logic [3:0]     mrf [4];
    logic [2:0]     mflags;
    logic [1:0]     mctl;
    int             mcnt = 0;
    int             macc = 0;

    always #5 clk = ~clk;

    alu4_wb #(.DEPTH(DEPTH), .NREGS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .in_zf      (in_zf),
        .in_cf      (in_cf),
        .in_sf      (in_sf),
        .in_ctl     (in_ctl),
        .in_rd      (in_rd),
        .wb_stall   (wb_stall),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .flag_zf    (flag_zf),
        .flag_cf    (flag_cf),
        .flag_sf    (flag_sf),
        .last_ctl   (last_ctl),
        .commit_cnt (commit_cnt)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [3:0] exp_read(input logic [1:0] a);
`ifdef ALU4_WB_BYPASS_EN
        if (q.size() != 0 && !wb_stall && q[0].rd == a) return q[0].res;
`endif
        return mrf[a];
    endfunction

    // Model update on each edge: commit head first, then accept if there was room
    always @(posedge clk) begin
        alu4_wb_entry_t e;
        bit dpop, dpush;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 4; i++) mrf[i] = 4'd0;
            mflags = 3'd0;
            mctl   = 2'd0;
            mcnt   = 0;
        end else begin
            dpop  = (q.size() != 0) && !wb_stall;
            dpush = in_valid && (q.size() != DEPTH);
            if (dpop) begin
                e = q.pop_front();
                mrf[e.rd] = e.res;
                mflags = {e.zf, e.cf, e.sf};
                mctl   = e.ctl;
                mcnt   = mcnt + 1;
            end
            if (dpush) begin
                e.res = in_res; e.zf = in_zf; e.cf = in_cf; e.sf = in_sf;
                e.ctl = in_ctl; e.rd = in_rd;
                q.push_back(e);
                macc++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {7'd0, in_ready}, {7'd0, rst_n && (q.size() != DEPTH)});
            chk("ra_data", {4'd0, ra_data}, {4'd0, exp_read(ra_addr)});
            chk("rb_data", {4'd0, rb_data}, {4'd0, exp_read(rb_addr)});
            chk("flags", {5'd0, flag_zf, flag_cf, flag_sf}, {5'd0, mflags});
            chk("last_ctl", {6'd0, last_ctl}, {6'd0, mctl});
            chk("commit_cnt", commit_cnt, 8'(mcnt % 256));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic z, input logic c,
                         input logic s, input logic [1:0] ct, input logic [1:0] d);
        in_valid = v; in_res = r; in_zf = z; in_cf = c; in_sf = s; in_ctl = ct; in_rd = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, guard;
        rst_n = 1'b0; wb_stall = 1'b0; ra_addr = 2'd0; rb_addr = 2'd0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {7'd0, in_ready}, 8'd0);
        chk("reset_cnt", commit_cnt, 8'd0);
        tick();
        rst_n = 1'b1;

        // 3+13: result 0, ZF=1 CF=1 SF=0, rd=2
        ra_addr = 2'd2;
        drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2);
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t1_rf2", {4'd0, ra_data}, 8'd0);
        chk("t1_flags", {5'd0, flag_zf, flag_cf, flag_sf}, 8'b110);
        chk("t1_last_ctl", {6'd0, last_ctl}, 8'd0);
        chk("t1_cnt", commit_cnt, 8'd1);

        // Stall fills the FIFO; third entry held until a pop frees a slot
        wb_stall = 1'b1;
        drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0);
        tick();
        drive(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1);
        tick();
        @(negedge clk);
        chk("t2_full_ready", {7'd0, in_ready}, 8'd0);
        drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 2'd3, 2'd3);
        tick();
        tick();
        @(negedge clk);
        chk("t2_held_ready", {7'd0, in_ready}, 8'd0);
        wb_stall = 1'b0;
        tick();
        @(negedge clk);
        chk("t2_ready_back", {7'd0, in_ready}, 8'd1);
        tick();
        in_valid = 1'b0;
        tick();
        ra_addr = 2'd0; rb_addr = 2'd1;
        @(negedge clk);
        chk("t2_rf0", {4'd0, ra_data}, 8'd1);
        chk("t2_rf1", {4'd0, rb_data}, 8'd2);
        chk("t2_flags", {5'd0, flag_zf, flag_cf, flag_sf}, 8'b001);
        chk("t2_cnt", commit_cnt, 8'd4);
        ra_addr = 2'd3;
        @(negedge clk);
        chk("t2_rf3", {4'd0, ra_data}, 8'd3);

        // Push and pop together at count 1, same rd: later value wins
        ra_addr = 2'd1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 4'(k), 1'b0, 1'b0, 1'b0, 2'd1, 2'd1);
            if (k > 0) begin
                @(negedge clk);
                chk("t3_ready", {7'd0, in_ready}, 8'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        wb_stall = 1'b1;
        @(negedge clk);
        chk("t3_rf1_at_push9", {4'd0, ra_data}, 8'd8);
        wb_stall = 1'b0;
        tick();
        @(negedge clk);
        chk("t3_rf1_final", {4'd0, ra_data}, 8'd9);

        // Reset with entries pending
        drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3);
        tick();
        in_valid = 1'b0;
        tick();
        ra_addr = 2'd3;
        @(negedge clk);
        chk("t4_rf3_pre", {4'd0, ra_data}, 8'd7);
        wb_stall = 1'b1;
        drive(1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3);
        tick();
        drive(1'b1, 4'd10, 1'b0, 1'b1, 1'b1, 2'd3, 2'd3);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_ready_in_reset", {7'd0, in_ready}, 8'd0);
        tick();
        rst_n = 1'b1;
        wb_stall = 1'b0;
        @(negedge clk);
        chk("t4_rf3", {4'd0, ra_data}, 8'd0);
        chk("t4_flags", {5'd0, flag_zf, flag_cf, flag_sf}, 8'd0);
        chk("t4_cnt", commit_cnt, 8'd0);
        chk("t4_ready_after", {7'd0, in_ready}, 8'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("t4_no_stale", commit_cnt, 8'd0);

        // 256 commits wrap the counter
        base = macc; guard = 0;
        while ((macc - base) < 256 && guard < 600) begin
            drive(1'b1, 4'($urandom_range(15)), 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 2'($urandom));
            tick();
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        @(negedge clk);
        chk("t5_wrap", commit_cnt, 8'd0);
        chk("t5_accepts", 8'(macc - base), 8'd0);

        // Read during the commit cycle
        ra_addr = 2'd2;
        drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
        tick();
        in_valid = 1'b0;
        tick();
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
`ifdef ALU4_WB_BYPASS_EN
        chk("t6_commit_cycle", {4'd0, ra_data}, 8'd5);
`else
        chk("t6_commit_cycle", {4'd0, ra_data}, 8'd3);
`endif
        tick();
        @(negedge clk);
        chk("t6_after", {4'd0, ra_data}, 8'd5);

        // Randomized traffic; data held while presented and not accepted
        for (int n = 0; n < 2000; n++) begin
            if (!(in_valid && !in_ready)) begin
                drive(1'($urandom_range(99) < 65), 4'($urandom_range(15)), 1'($urandom),
                      1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
            end
            wb_stall = ($urandom_range(99) < 30);
            ra_addr  = 2'($urandom);
            rb_addr  = 2'($urandom);
            rst_n    = ($urandom_range(199) != 0);
            tick();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu4_wb.md
# alu4_wb

Write-back stage directly downstream of the 4-bit ALU `alu4`. It accepts each ALU result with its flags (ZF, CF, SF) and a destination register index through a valid/ready handshake. Accepted entries wait in a small in-order FIFO, then commit to a 4×4-bit register file and an architectural flags register. The register file's two combinational read ports supply operands back to the issue logic ahead of the ALU.

## Interface
Parameters:
- DEPTH, 2, FIFO entries between ALU output and commit (legal 2..4)
- NREGS, 4, register-file entries (index width 2)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  ALU result presented
- in_ready  out  1  stage can accept this cycle
- in_res  in  4  ALU result
- in_zf / in_cf / in_sf  in  1 each  ALU zero / carry / sign flags
- in_ctl  in  2  ALU op code, carried as tag
- in_rd  in  2  destination register index
- wb_stall  in  1  blocks commit this cycle
- ra_addr / rb_addr  in  2 each  read-port addresses
- ra_data / rb_data  out  4 each  read-port data (combinational)
- flag_zf / flag_cf / flag_sf  out  1 each  architectural flags
- last_ctl  out  2  in_ctl of most recent commit
- commit_cnt  out  8  number of commits, wraps 255→0

## Operation
- Push: entry {res, zf, cf, sf, ctl, rd} accepted on an edge where in_valid && in_ready.
- in_ready = rst_n && (count != DEPTH). No same-cycle pass-through when full.
- Commit: on an edge where count != 0 && !wb_stall, the head entry pops and updates, all together:
  - rf[rd] ← res
  - flags ← {zf, cf, sf}
  - last_ctl ← ctl
  - commit_cnt + 1
- Occupancy FSM:
  - EMPTY(count 0): push → PARTIAL (or FULL if DEPTH is reached).
  - PARTIAL: push only → +1; pop only → −1; push and pop together → count unchanged, FIFO order preserved.
  - FULL: no push; pop → PARTIAL.
- The FIFO is strictly in order. Back-to-back writes to the same rd leave the later value.
- in_valid while !in_ready: the entry is ignored, and upstream must hold it.
- Reset (rst_n low at an edge), including mid-operation:
  - count → 0 and pending entries are discarded.
  - rf all 0, flags 0, last_ctl 0, commit_cnt 0.
  - in_ready is 0 while rst_n is low and 1 on the first cycle after.

## Timing
- Entry accepted at edge N commits at edge N+1 at the earliest (count was 0, no stall). It is visible on ra_data/rb_data and the flag outputs after edge N+1.
- Each stalled cycle adds one cycle of latency.
- Sustained throughput is 1 entry/cycle with wb_stall low.
- Read ports are combinational from rf, with no added latency.

## Configuration
- ALU4_WB_BYPASS_EN defined:
  - If a read address equals the head rd on a cycle where that commit will occur (count != 0 && !wb_stall), the port returns the head res combinationally.
  - Flag outputs remain registered.
- Undefined: read ports show rf only, so the new value appears the cycle after the commit edge.

## Structure
- Package alu4_pkg:
  - the ALU ctl encoding localparams (CTL_0..CTL_3)
  - typedef alu4_wb_entry_t {res[3:0], zf, cf, sf, ctl[1:0], rd[1:0]}
  - FLAG_W = 3
- Sub-module alu4_wb_fifo:
  - parameterised DEPTH circular buffer of alu4_wb_entry_t
  - head/tail pointers wrap at DEPTH
  - outputs count, full, empty, head
- The top level holds the register file, flags, counter and bypass mux.

## Test plan
- Reset, then push {res=0, zf=1, cf=1, sf=0, ctl=0, rd=2} (3+13 result) with no stall → after the next edge, rf[2]=0, flags ZF=1 CF=1 SF=0, last_ctl=0, commit_cnt=1.
- Hold wb_stall=1 and push 3 entries with DEPTH=2 → in_ready drops after the 2nd accept and the 3rd is held. Release the stall → commits occur in order and in_ready returns after the first pop.
- Simultaneous push and pop with count=1 for 10 cycles (rd=1, res 0..9) → count stays 1, and rf[1] = 8 when the push of 9 occurs.
- Assert rst_n=0 for one cycle with 2 entries pending and rf[3]=7 → all of the following are 0, and no stale commits occur after reset:
  - rf[3], flags, commit_cnt
  - in_ready during reset
- Issue 256 commits → commit_cnt wraps to 0.
- With ALU4_WB_BYPASS_EN, ra_addr=2 during the commit cycle of {res=5, rd=2} → ra_data=5 on that same cycle. Without the macro, ra_data=old value, then 5 the next cycle.
